// File: rtl/axi4_mem_pkg.sv
// Shared AXI4 encodings, widths and FSM state types for the AXI4 memory responder.
package axi4_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Only full-width INCR bursts touch the RAM.
    function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_INCR) && (size == 3'd3);
    endfunction

endpackage

// File: rtl/axi4_mem_array.sv
// Simple dual-port RAM: byte-enabled write on port A, registered read-first read on port B.
module axi4_mem_array
    import axi4_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2 = 12
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [MEM_WORDS_LOG2-1:0] waddr_i,
    input  logic [AXI_STRB_W-1:0]     wbe_i,
    input  logic [AXI_DATA_W-1:0]     wdata_i,
    input  logic                      re_i,
    input  logic [MEM_WORDS_LOG2-1:0] raddr_i,
    output logic [AXI_DATA_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 1 << MEM_WORDS_LOG2;

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    // No reset so the array maps onto block RAM; non-blocking read gives read-first.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wbe_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by an internal RAM; independent single-outstanding read and write paths.
module axi4_mem_responder
    import axi4_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned MEM_WORDS_LOG2 = 12
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [AXI_ID_WIDTH-1:0] s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [63:0]             s_axi_wdata,
    input  logic [7:0]              s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0] s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0] s_axi_rid,
    output logic [63:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned IW = MEM_WORDS_LOG2;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                             s_axi_awaddr[2:0], s_axi_awaddr[ADDR_WIDTH-1:IW+3],
                             s_axi_araddr[2:0], s_axi_araddr[ADDR_WIDTH-1:IW+3]};

    // Holds off address acceptance until the first clock after reset release.
    logic init_q;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) init_q <= 1'b0;
        else        init_q <= 1'b1;
    end

    w_state_t                w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0] w_id_q;
    logic [IW-1:0]           w_idx_q;
    logic [7:0]              w_len_q, w_cnt_q;
    logic                    w_burst_err_q, w_last_err_q;
    logic                    aw_hs, w_hs, w_last_beat;

    assign s_axi_awready = init_q && (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = (s_axi_bvalid && (w_burst_err_q || w_last_err_q)) ? RESP_SLVERR
                                                                             : RESP_OKAY;
    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_cnt_q == w_len_q);

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q     <= W_IDLE;
            w_id_q        <= '0;
            w_idx_q       <= '0;
            w_len_q       <= '0;
            w_cnt_q       <= '0;
            w_burst_err_q <= 1'b0;
            w_last_err_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                w_id_q        <= s_axi_awid;
                w_idx_q       <= s_axi_awaddr[IW+2:3];
                w_len_q       <= s_axi_awlen;
                w_cnt_q       <= '0;
                w_burst_err_q <= !burst_legal(s_axi_awburst, s_axi_awsize);
                w_last_err_q  <= 1'b0;
            end
            if (w_hs) begin
                w_idx_q <= w_idx_q + IW'(1);
                w_cnt_q <= w_cnt_q + 8'(1);
                if (s_axi_wlast != w_last_beat) w_last_err_q <= 1'b1;
            end
        end
    end

    r_state_t                r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0] r_id_q;
    logic [IW-1:0]           r_idx_q;
    logic [7:0]              r_len_q, r_cnt_q;
    logic                    r_err_q;
    logic                    ar_hs, r_hs;
    logic [AXI_DATA_W-1:0]   ram_rdata;

    assign s_axi_arready = init_q && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rid     = r_id_q;
    assign s_axi_rlast   = s_axi_rvalid && (r_cnt_q == r_len_q);
    assign s_axi_rresp   = (s_axi_rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    // RAM output only changes in R_FETCH, so rdata is stable while waiting on rready.
    assign s_axi_rdata   = (s_axi_rvalid && !r_err_q) ? ram_rdata : '0;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_FETCH;
            R_FETCH: r_state_d = R_DATA;
            R_DATA:  if (r_hs) r_state_d = s_axi_rlast ? R_IDLE : R_FETCH;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                r_id_q  <= s_axi_arid;
                r_idx_q <= s_axi_araddr[IW+2:3];
                r_len_q <= s_axi_arlen;
                r_cnt_q <= '0;
                r_err_q <= !burst_legal(s_axi_arburst, s_axi_arsize);
            end else if (r_hs && !s_axi_rlast) begin
                r_idx_q <= r_idx_q + IW'(1);
                r_cnt_q <= r_cnt_q + 8'(1);
            end
        end
    end

    axi4_mem_array #(
        .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
    ) u_array (
        .clk_i   (aclk),
        .we_i    (w_hs && !w_burst_err_q),
        .waddr_i (w_idx_q),
        .wbe_i   (s_axi_wstrb),
        .wdata_i (s_axi_wdata),
        .re_i    (r_state_q == R_FETCH),
        .raddr_i (r_idx_q),
        .rdata_o (ram_rdata)
    );

endmodule
